// File: rtl/uhci_mem_arbiter.sv
// Two-requester arbiter for port A of the UHCI descriptor/data memory.
// Round-robin with pre-SOF FSM priority, per-requester lock and tagged read return.
module uhci_mem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int MEM_NUM_COL    = 4,
  parameter int MEM_COL_WIDTH  = 32,
  parameter int MEM_DATA_WIDTH = MEM_COL_WIDTH * MEM_NUM_COL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pre_sof,

  input  logic                      fsm_req,
  input  logic                      fsm_lock,
  input  logic [MEM_NUM_COL-1:0]    fsm_we,
  input  logic [MEM_ADDR_WIDTH-1:0] fsm_addr,
  input  logic [MEM_DATA_WIDTH-1:0] fsm_wdata,
  output logic                      fsm_gnt,
  output logic                      fsm_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] fsm_rdata,

  input  logic                      axi_req,
  input  logic                      axi_lock,
  input  logic [MEM_NUM_COL-1:0]    axi_we,
  input  logic [MEM_ADDR_WIDTH-1:0] axi_addr,
  input  logic [MEM_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_gnt,
  output logic                      axi_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] axi_rdata,

  output logic                      mem_en,
  output logic [MEM_NUM_COL-1:0]    mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_din,
  input  logic [MEM_DATA_WIDTH-1:0] mem_dout
);

  localparam logic [1:0] LOCK_NONE = 2'd0;
  localparam logic [1:0] LOCK_FSM  = 2'd1;
  localparam logic [1:0] LOCK_AXI  = 2'd2;

  logic [1:0]                r_lock;
  logic                      r_last_axi;
  logic                      r_mem_en;
  logic [MEM_NUM_COL-1:0]    r_mem_we;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
  logic [MEM_DATA_WIDTH-1:0] r_mem_din;
  logic                      r_tag1_vld;
  logic                      r_tag1_axi;
  logic                      r_tag2_vld;
  logic                      r_tag2_axi;

  logic                      w_gnt_fsm;
  logic                      w_gnt_axi;
  logic                      w_any_gnt;
  logic                      w_contend;
  logic                      w_sel_lock;
  logic [MEM_NUM_COL-1:0]    w_sel_we;
  logic [MEM_ADDR_WIDTH-1:0] w_sel_addr;
  logic [MEM_DATA_WIDTH-1:0] w_sel_wdata;
  logic                      w_rd_beat;
  logic [1:0]                w_lock_next;

  // Only the unlocked, non-pre-SOF, both-requesting case moves the round-robin pointer.
  assign w_contend = rst_n && !pre_sof && (r_lock == LOCK_NONE) && fsm_req && axi_req;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_gnt_fsm = 1'b0;
    w_gnt_axi = 1'b0;
    if (!rst_n) begin
      w_gnt_fsm = 1'b0;
    end else if (pre_sof) begin
      w_gnt_fsm = fsm_req;
    end else begin
      case (r_lock)
        LOCK_FSM: w_gnt_fsm = fsm_req;
        LOCK_AXI: w_gnt_axi = axi_req;
        default: begin
          if (fsm_req && axi_req) begin
            w_gnt_fsm = r_last_axi;
            w_gnt_axi = !r_last_axi;
          end else begin
            w_gnt_fsm = fsm_req;
            w_gnt_axi = axi_req;
          end
        end
      endcase
    end
  end

  assign w_any_gnt   = w_gnt_fsm || w_gnt_axi;
  assign w_sel_lock  = w_gnt_axi ? axi_lock  : fsm_lock;
  assign w_sel_we    = w_gnt_axi ? axi_we    : fsm_we;
  assign w_sel_addr  = w_gnt_axi ? axi_addr  : fsm_addr;
  assign w_sel_wdata = w_gnt_axi ? axi_wdata : fsm_wdata;
  assign w_rd_beat   = w_any_gnt && (w_sel_we == '0);

  // An accepted beat decides the lock outright; otherwise an idle owner or pre-SOF
  // (for an AXI lock) releases it.
  always_comb begin
    w_lock_next = r_lock;
    if (w_any_gnt) begin
      if (w_sel_lock) w_lock_next = w_gnt_axi ? LOCK_AXI : LOCK_FSM;
      else            w_lock_next = LOCK_NONE;
    end else if ((r_lock == LOCK_FSM && !fsm_req) || (r_lock == LOCK_AXI && !axi_req)) begin
      w_lock_next = LOCK_NONE;
    end else if (pre_sof && (r_lock == LOCK_AXI)) begin
      w_lock_next = LOCK_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock     <= LOCK_NONE;
      r_last_axi <= 1'b1;
      r_mem_en   <= 1'b0;
      r_mem_we   <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_tag1_vld <= 1'b0;
      r_tag1_axi <= 1'b0;
      r_tag2_vld <= 1'b0;
      r_tag2_axi <= 1'b0;
    end else begin
      r_lock <= w_lock_next;
      if (w_contend) r_last_axi <= w_gnt_axi;

      r_mem_en <= w_any_gnt;
      r_mem_we <= w_any_gnt ? w_sel_we : '0;
      if (w_any_gnt) begin
        r_mem_addr <= w_sel_addr;
        r_mem_din  <= w_sel_wdata;
      end

      r_tag1_vld <= w_rd_beat;
      r_tag1_axi <= w_gnt_axi;
      r_tag2_vld <= r_tag1_vld;
      r_tag2_axi <= r_tag1_axi;
    end
  end

  assign fsm_gnt    = w_gnt_fsm;
  assign axi_gnt    = w_gnt_axi;
  assign fsm_rvalid = r_tag2_vld && !r_tag2_axi;
  assign axi_rvalid = r_tag2_vld &&  r_tag2_axi;
  assign fsm_rdata  = mem_dout;
  assign axi_rdata  = mem_dout;

  assign mem_en   = r_mem_en;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_uhci_mem_arbiter.sv
// Bench for uhci_mem_arbiter: per-cycle vector table with a read-return scoreboard
// and a behavioural dual_memory port A model.
module tb_uhci_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         pre_sof;
  logic         fsm_req, fsm_lock, fsm_gnt, fsm_rvalid;
  logic [3:0]   fsm_we;
  logic [5:0]   fsm_addr;
  logic [127:0] fsm_wdata, fsm_rdata;
  logic         axi_req, axi_lock, axi_gnt, axi_rvalid;
  logic [3:0]   axi_we;
  logic [5:0]   axi_addr;
  logic [127:0] axi_wdata, axi_rdata;
  logic         mem_en;
  logic [3:0]   mem_we;
  logic [5:0]   mem_addr;
  logic [127:0] mem_din, mem_dout;

  uhci_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pre_sof(pre_sof),
    .fsm_req(fsm_req), .fsm_lock(fsm_lock), .fsm_we(fsm_we), .fsm_addr(fsm_addr),
    .fsm_wdata(fsm_wdata), .fsm_gnt(fsm_gnt), .fsm_rvalid(fsm_rvalid), .fsm_rdata(fsm_rdata),
    .axi_req(axi_req), .axi_lock(axi_lock), .axi_we(axi_we), .axi_addr(axi_addr),
    .axi_wdata(axi_wdata), .axi_gnt(axi_gnt), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, pre;
    logic       fr, fl;
    logic [3:0] fwe;
    logic [5:0] fa;
    logic       ar, al;
    logic [3:0] awe;
    logic [5:0] aa;
    logic       efg, eag;
  } vec_t;

  typedef struct {
    logic         vld;
    logic         axi;
    logic [127:0] data;
  } tag_t;

  function automatic logic [127:0] init_word(input int i);
    if (i == 5) return {4{32'hA5A5_A5A5}};
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  function automatic logic [127:0] wdata_of(input logic axi, input logic [5:0] a);
    logic [31:0] base;
    base = {(axi ? 8'hDA : 8'hF5), 18'h0, a};
    return {base ^ 32'h3000_0000, base ^ 32'h2000_0000, base ^ 32'h1000_0000, base};
  endfunction

  function automatic vec_t mk(input logic rst, input logic pre,
                              input logic fr, input logic fl, input logic [3:0] fwe,
                              input logic [5:0] fa,
                              input logic ar, input logic al, input logic [3:0] awe,
                              input logic [5:0] aa,
                              input logic efg, input logic eag);
    vec_t v;
    v.rst = rst; v.pre = pre;
    v.fr = fr; v.fl = fl; v.fwe = fwe; v.fa = fa;
    v.ar = ar; v.al = al; v.awe = awe; v.aa = aa;
    v.efg = efg; v.eag = eag;
    return v;
  endfunction

  // Port A memory: 1-cycle synchronous read (old data), per-column write enables.
  logic [127:0] mem [64];
  logic         mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      for (int c = 0; c < 4; c++)
        if (mem_we[c]) mem[mem_addr][c*32 +: 32] <= mem_din[c*32 +: 32];
      mem_dout <= mem[mem_addr];
    end
  end

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] shadow [64];
  tag_t         sbq [$];
  vec_t         vecs [$];
  logic         exp_en;
  logic [3:0]   exp_we;
  logic [5:0]   exp_addr;
  logic [127:0] exp_din;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_idle();
    tag_t t;
    t.vld = 1'b0; t.axi = 1'b0; t.data = '0;
    sbq.push_back(t);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    tag_t         t, e;
    logic         ax;
    logic [3:0]   we;
    logic [5:0]   a;
    logic [127:0] w;
    string        p;
    @(posedge clk);
    #1;
    rst_n     = !v.rst;
    pre_sof   = v.pre;
    fsm_req   = v.fr;  fsm_lock = v.fl; fsm_we = v.fwe; fsm_addr = v.fa;
    fsm_wdata = wdata_of(1'b0, v.fa);
    axi_req   = v.ar;  axi_lock = v.al; axi_we = v.awe; axi_addr = v.aa;
    axi_wdata = wdata_of(1'b1, v.aa);
    #5;
    p = $sformatf("c%0d", idx);
    check({p, " fsm_gnt"},  fsm_gnt,  v.efg);
    check({p, " axi_gnt"},  axi_gnt,  v.eag);
    check({p, " mem_en"},   mem_en,   exp_en);
    check({p, " mem_we"},   mem_we,   exp_we);
    check({p, " mem_addr"}, mem_addr, exp_addr);
    check({p, " mem_din"},  mem_din,  exp_din);
    e = sbq.pop_front();
    check({p, " fsm_rvalid"}, fsm_rvalid, e.vld && !e.axi);
    check({p, " axi_rvalid"}, axi_rvalid, e.vld &&  e.axi);
    if (e.vld)
      check({p, " rdata"}, e.axi ? axi_rdata : fsm_rdata, e.data);

    t.vld = 1'b0; t.axi = 1'b0; t.data = '0;
    if (v.rst) begin
      exp_en = 1'b0; exp_we = '0; exp_addr = '0; exp_din = '0;
      sbq.delete();
      push_idle();
      push_idle();
    end else if (v.efg || v.eag) begin
      ax = v.eag;
      we = ax ? v.awe : v.fwe;
      a  = ax ? v.aa  : v.fa;
      w  = wdata_of(ax, a);
      exp_en = 1'b1; exp_we = we; exp_addr = a; exp_din = w;
      if (we == 4'h0) begin
        t.vld = 1'b1; t.axi = ax; t.data = shadow[a];
      end else begin
        for (int c = 0; c < 4; c++)
          if (we[c]) shadow[a][c*32 +: 32] = w[c*32 +: 32];
      end
      sbq.push_back(t);
    end else begin
      exp_en = 1'b0; exp_we = '0;
      sbq.push_back(t);
    end
  endtask

  initial begin
    rst_n = 1'b0; pre_sof = 1'b0;
    fsm_req = 1'b0; fsm_lock = 1'b0; fsm_we = '0; fsm_addr = '0; fsm_wdata = '0;
    axi_req = 1'b0; axi_lock = 1'b0; axi_we = '0; axi_addr = '0; axi_wdata = '0;
    exp_en = 1'b0; exp_we = '0; exp_addr = '0; exp_din = '0;
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    push_idle();
    push_idle();

    //                rst pre fr fl fwe   fa   ar al awe   aa   efg eag
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0)); // reset
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd5,  0, 0, 4'h0, 6'd0,  1, 0)); // single FSM read
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd1,  1, 0, 4'h0, 6'd2,  1, 0)); // round robin
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd3,  1, 0, 4'h0, 6'd2,  0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd3,  1, 0, 4'h0, 6'd7,  1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd8,  1, 0, 4'h0, 6'd7,  0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd8,  1, 0, 4'h0, 6'd9,  1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd10, 1, 0, 4'h0, 6'd9,  0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd15, 1, 1, 4'h0, 6'd16, 1, 0)); // AXI lock burst
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd17, 1, 1, 4'h0, 6'd16, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd17, 1, 1, 4'hF, 6'd20, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd17, 1, 0, 4'h0, 6'd18, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd17, 0, 0, 4'h0, 6'd0,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  1, 1, 4'h0, 6'd21, 0, 1)); // pre_sof breaks lock
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  1, 1, 4'h0, 6'd22, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 4'h0, 6'd23, 1, 1, 4'h0, 6'd24, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 6'd0,  1, 1, 4'h0, 6'd24, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd25, 1, 1, 4'h0, 6'd24, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  1, 1, 4'h0, 6'd24, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  1, 0, 4'h0, 6'd27, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 4'h0, 6'd28, 0, 0, 4'h0, 6'd0,  1, 0)); // FSM lock, then idle
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  1, 0, 4'h0, 6'd29, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  1, 0, 4'h0, 6'd29, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h3, 6'd63, 0, 0, 4'h0, 6'd0,  1, 0)); // partial write
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  1, 0, 4'h0, 6'd63, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 6'd5,  0, 0, 4'h0, 6'd0,  1, 0)); // read, then reset
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 6'd0,  0, 0, 4'h0, 6'd0,  0, 0));

    foreach (vecs[i]) run_vec(i, vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
